// File: rtl/ram_responder_pkg.sv
// Shared parameters and state encoding for the RAM responder.
// All other files of the block import this package.
package ram_responder_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ram_responder_if.sv
// Request/response bus between an initiator (master) and the RAM responder (slave).
// A request transfers on a rising edge when req_valid && req_ready; a response pops when rsp_valid && rsp_ready.
interface ram_responder_if
    import ram_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              init_done;
    state_t            state;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, init_done, state
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, init_done, state
    );

endinterface

// File: rtl/ram_responder_resp_fifo.sv
// Two-entry response queue holding read data until the initiator consumes it.
// Caller guarantees push only when not full (or popping) and pop only when not empty.
module resp_fifo
    import ram_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] entry [FIFO_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) entry[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= wdata;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = entry[rd_ptr];
    assign full  = (count == 2'(FIFO_DEPTH));
    assign empty = (count == 2'd0);

endmodule

// File: rtl/ram_responder.sv
// Single-port RAM behind a valid/ready request bus: clears itself after reset, then serves
// writes (no response) and reads (data returned in order through a two-entry queue).
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input logic            clk,
    input logic            rst,
    ram_responder_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        RES_MAX   = 2'(FIFO_DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] sweep;
    logic [1:0]        reserved;
    logic              init_done_q;
    logic              rd_pend;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              req_ready_c;
    logic              accept;
    logic              rd_acc;
    logic              rsp_valid_c;
    logic              pop;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign req_ready_c = (state == ST_RUN) && (reserved < RES_MAX);
    assign accept      = bus.req_valid && req_ready_c;
    assign rd_acc      = accept && !bus.req_we;

    // The read issued last cycle sits in rd_q; it is handed out directly when the queue is empty.
    assign rsp_valid_c = !fifo_empty || rd_pend;
    assign pop         = rsp_valid_c && bus.rsp_ready;
    assign fifo_pop    = bus.rsp_ready && !fifo_empty;
    assign fifo_push   = rd_pend && !(fifo_empty && bus.rsp_ready) && (!fifo_full || fifo_pop);

    assign mem_we    = (state == ST_INIT) || (accept && bus.req_we);
    assign mem_addr  = (state == ST_INIT) ? sweep : bus.req_addr;
    assign mem_wdata = (state == ST_INIT) ? '0 : bus.req_wdata;

    // No reset on the array so it maps onto block RAM; the INIT sweep does the clearing.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        rd_q <= mem[bus.req_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            sweep       <= '0;
            init_done_q <= 1'b0;
            reserved    <= '0;
            rd_pend     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep <= sweep + 1'b1;
                    if (sweep == LAST_ADDR) begin
                        state       <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_INIT;
            endcase
            rd_pend <= rd_acc;
            case ({rd_acc, pop})
                2'b10:   reserved <= reserved + 1'b1;
                2'b01:   reserved <= reserved - 1'b1;
                default: reserved <= reserved;
            endcase
        end
    end

    resp_fifo #(.DATA_W(DATA_W)) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (rd_q),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_rdata = !fifo_empty ? fifo_rdata : (rd_pend ? rd_q : '0);
    assign bus.init_done = init_done_q;
    assign bus.state     = state;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed vector table, hand-written stall/reset sequences and
// randomized traffic, all checked every cycle against a transaction-level memory/queue model.
module tb_ram_responder;
    import ram_responder_pkg::*;

    localparam int AW          = 8;
    localparam int DW          = 16;
    localparam int DEPTH       = 256;
    localparam int INIT_CYCLES = 256;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    ram_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got [$];
    bit            running;
    int            init_cnt;
    bit            last_acc;
    vec_t          vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        running  = 1'b0;
        init_cnt = 0;
        last_acc = 1'b0;
        exp_q.delete();
        foreach (mem_m[i]) mem_m[i] = '0;
    endtask

    // Called at a falling edge: checks outputs, then applies the coming rising edge to the model.
    task automatic cycle();
        bit exp_ready;
        bit exp_valid;
        bit acc;
        exp_ready = running && (exp_q.size() < FIFO_DEPTH);
        exp_valid = (exp_q.size() > 0);
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("init_done", 32'(bus.init_done), 32'(running));
        check("state", 32'(bus.state == ST_RUN), 32'(running));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
        if (exp_valid) check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_q[0]));
        acc = exp_ready && bus.req_valid;
        if (exp_valid && bus.rsp_ready) void'(exp_q.pop_front());
        if (acc) begin
            if (bus.req_we) mem_m[bus.req_addr] = bus.req_wdata;
            else            exp_q.push_back(mem_m[bus.req_addr]);
        end
        last_acc = acc;
        if (!running) begin
            init_cnt++;
            if (init_cnt == INIT_CYCLES) running = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_init_done", 32'(bus.init_done), 0);
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_init();
        int n = 0;
        while (!bus.init_done && n < INIT_CYCLES + 50) begin
            cycle();
            n++;
        end
        check("init_cycles", n, INIT_CYCLES);
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 20);
        check("issue_accept", 32'(last_acc), 1);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int n_acc;
        int idx;
        int n;
        bit acc_now;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b0;
        #1;
        do_reset();

        // Clear sweep length, then a read of a never-written address.
        wait_init();
        bus.rsp_ready = 1'b1;
        issue(1'b0, 8'h80, '0);
        check("init_read_valid", 32'(bus.rsp_valid), 1);
        check("init_read_data", 32'(bus.rsp_rdata), 0);
        idle(1);

        vecs[0]  = '{1'b1, 8'h05, 16'h1234, 16'h0000};
        vecs[1]  = '{1'b0, 8'h05, 16'h0000, 16'h1234};
        vecs[2]  = '{1'b1, 8'h00, 16'hA000, 16'h0000};
        vecs[3]  = '{1'b1, 8'h01, 16'hA001, 16'h0000};
        vecs[4]  = '{1'b1, 8'h02, 16'hA002, 16'h0000};
        vecs[5]  = '{1'b1, 8'h03, 16'hA003, 16'h0000};
        vecs[6]  = '{1'b0, 8'h80, 16'h0000, 16'h0000};
        vecs[7]  = '{1'b1, 8'hFF, 16'hFFFF, 16'h0000};
        vecs[8]  = '{1'b0, 8'hFF, 16'h0000, 16'hFFFF};
        vecs[9]  = '{1'b0, 8'h00, 16'h0000, 16'hA000};
        vecs[10] = '{1'b1, 8'h10, 16'h5A5A, 16'h0000};
        vecs[11] = '{1'b0, 8'h10, 16'h0000, 16'h5A5A};
        bus.rsp_ready = 1'b1;
        foreach (vecs[i]) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            if (!vecs[i].we) begin
                check("vec_rsp_valid", 32'(bus.rsp_valid), 1);
                check("vec_rdata", 32'(bus.rsp_rdata), 32'(vecs[i].exp));
            end
        end
        idle(1);

        // Back-to-back reads of 0..3 with the response side always ready.
        got.delete();
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_addr  = AW'(i);
            if (bus.rsp_valid) got.push_back(bus.rsp_rdata);
            if (bus.req_ready) n_acc++;
            cycle();
        end
        bus.req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (bus.rsp_valid) got.push_back(bus.rsp_rdata);
            cycle();
        end
        check("b2b_accepts", n_acc, 4);
        check("b2b_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            check("b2b_rsp", (i < got.size()) ? 32'(got[i]) : 32'hDEADBEEF, 32'hA000 + i);

        // Stall the response side while reading 1,2,3.
        bus.rsp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            bus.req_valid = (idx < 3);
            bus.req_we    = 1'b0;
            bus.req_addr  = AW'(idx + 1);
            acc_now = bus.req_valid && bus.req_ready;
            cycle();
            if (acc_now) idx++;
        end
        check("stall_accepts", idx, 2);
        check("stall_ready_low", 32'(bus.req_ready), 0);
        check("stall_valid", 32'(bus.rsp_valid), 1);
        check("stall_hold", 32'(bus.rsp_rdata), 32'hA001);
        cycle();
        check("stall_hold_later", 32'(bus.rsp_rdata), 32'hA001);
        bus.rsp_ready = 1'b1;
        got.delete();
        n = 0;
        while (got.size() < 3 && n < 20) begin
            bus.req_valid = (idx < 3);
            acc_now = bus.req_valid && bus.req_ready;
            if (bus.rsp_valid) got.push_back(bus.rsp_rdata);
            cycle();
            if (acc_now) idx++;
            n++;
        end
        bus.req_valid = 1'b0;
        check("stall_count", got.size(), 3);
        for (int i = 0; i < 3; i++)
            check("stall_rsp", (i < got.size()) ? 32'(got[i]) : 32'hDEADBEEF, 32'hA001 + i);
        idle(2);

        // Reset with two responses queued, then confirm the memory was re-cleared.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 8'h05, '0);
        issue(1'b0, 8'h01, '0);
        cycle();
        check("pre_rst_valid", 32'(bus.rsp_valid), 1);
        do_reset();
        wait_init();
        bus.rsp_ready = 1'b1;
        issue(1'b0, 8'h05, '0);
        check("post_rst_valid", 32'(bus.rsp_valid), 1);
        check("post_rst_data", 32'(bus.rsp_rdata), 0);
        idle(1);

        // Random traffic with a reset in the middle; the initiator holds unaccepted requests.
        for (int c = 0; c < 700; c++) begin
            if (c == 250) begin
                do_reset();
            end
            if (!(bus.req_valid && !last_acc)) begin
                bus.req_valid = ($urandom_range(0, 3) != 0);
                bus.req_we    = 1'($urandom_range(0, 1));
                bus.req_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255))
                                                            : AW'($urandom_range(0, 7));
                bus.req_wdata = DW'($urandom_range(0, 16'hFFFF));
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.rsp_ready = 1'b1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
